tanh_layer_sequencer: RTL and testbench

//  Streams a flattened vector of NUM_ELEM IEEE-754 single-precision values through one

---
 rtl/cnn_pkg.sv | 14 +
 rtl/tanh_layer_sequencer.sv | 141 ++++++++++++++
 tb/tb_tanh_layer_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the sequencer state encoding.
package cnn_pkg;

  localparam logic [31:0] FLOAT_ONE  = 32'h3F800000;
  localparam logic [31:0] FLOAT_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tanh_layer_sequencer.sv
// Streams a flattened float vector through one shared iterative tanh unit and
// collects the results into an output vector that updates atomically at DONE.
module tanh_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_ELEM   = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [DATA_WIDTH*NUM_ELEM-1:0]   data_in,
  output logic [DATA_WIDTH*NUM_ELEM-1:0]   data_out,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [DATA_WIDTH-1:0]            tanh_x,
  output logic                             tanh_reset,
  input  logic [DATA_WIDTH-1:0]            tanh_out,
  input  logic                             tanh_finished
);

  localparam int unsigned IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned VEC_W = DATA_WIDTH * NUM_ELEM;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] in_buf  [NUM_ELEM];
  logic [DATA_WIDTH-1:0] res_buf [NUM_ELEM];
  logic [IDX_W-1:0]      idx;
  logic [WD_W-1:0]       wdog;

  logic                  accept_c;
  logic                  expired_c;
  logic                  capture_c;
  logic                  last_c;
  logic [IDX_W-1:0]      idx_inc_c;

  logic [VEC_W-1:0]      data_out_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] tanh_x_d;
  logic                  tanh_reset_d;

  assign accept_c  = (state == IDLE) && start;
  assign expired_c = (state == WAIT) && !tanh_finished && (wdog == WD_W'(TIMEOUT));
  assign capture_c = (state == WAIT) && (tanh_finished || (wdog == WD_W'(TIMEOUT)));
  assign last_c    = (idx == IDX_W'(NUM_ELEM - 1));
  assign idx_inc_c = idx + IDX_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; finished is only looked at in WAIT, never in LOAD
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: next_state = WAIT;
      WAIT: if (capture_c) next_state = last_c ? DONE : LOAD;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    data_out_d   = data_out;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = err;
    tanh_x_d     = tanh_x;
    tanh_reset_d = (next_state == IDLE) || (next_state == LOAD);
    if (accept_c) begin
      busy_d   = 1'b1;
      err_d    = 1'b0;
      tanh_x_d = data_in[DATA_WIDTH-1:0];
    end
    if (expired_c) err_d = 1'b1;
    if (capture_c && !last_c) tanh_x_d = in_buf[idx_inc_c];
    if (state == DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      for (int i = 0; i < NUM_ELEM; i++) begin
        data_out_d[i*DATA_WIDTH +: DATA_WIDTH] = res_buf[i];
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      tanh_x     <= '0;
      tanh_reset <= 1'b1;
    end else begin
      data_out   <= data_out_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      tanh_x     <= tanh_x_d;
      tanh_reset <= tanh_reset_d;
    end
  end

  // Element buffers, index and watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        in_buf[i]  <= '0;
        res_buf[i] <= '0;
      end
      idx  <= '0;
      wdog <= '0;
    end else begin
      if (accept_c) begin
        for (int i = 0; i < NUM_ELEM; i++) begin
          in_buf[i]  <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
          res_buf[i] <= '0;
        end
        idx <= '0;
      end
      if (state == LOAD) wdog <= '0;
      else if ((state == WAIT) && !capture_c) wdog <= wdog + WD_W'(1);
      if (capture_c) begin
        res_buf[idx] <= tanh_finished ? tanh_out : DATA_WIDTH'(FLOAT_QNAN);
        if (!last_c) idx <= idx_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_tanh_layer_sequencer.sv
// Directed bench for tanh_layer_sequencer with a behavioural tanh-unit stub.
module tb_tanh_layer_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned NE = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [DW*NE-1:0] data_in;
  logic [DW*NE-1:0] data_out;
  logic            busy;
  logic            done;
  logic            err;
  logic [DW-1:0]   tanh_x;
  logic            tanh_reset;
  logic [DW-1:0]   tanh_out;
  logic            tanh_finished;

  int n_cmp = 0;
  int n_bad = 0;

  tanh_layer_sequencer #(.DATA_WIDTH(DW), .NUM_ELEM(NE), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .data_out(data_out), .busy(busy), .done(done), .err(err),
    .tanh_x(tanh_x), .tanh_reset(tanh_reset),
    .tanh_out(tanh_out), .tanh_finished(tanh_finished)
  );

  always #5 clk = ~clk;

  // Stub unit configuration
  logic [31:0] lat_x   = 32'hFFFFFFFF;
  int          lat_cfg = 0;
  bit          hang_en = 1'b0;
  logic [31:0] hang_x  = 32'h0;

  function automatic logic [31:0] f_tanh(input logic [31:0] x);
    case (x)
      32'hC0000000: return 32'hBF800000;
      32'h40000000: return 32'h3F800000;
      32'hBF800000: return 32'hBF800000;
      32'h3F800000: return 32'h3F800000;
      32'h3F000000: return 32'h3EEC9A9F;
      32'h00000000: return 32'h00000000;
      default:      return x ^ 32'h1;
    endcase
  endfunction

  function automatic int lat_of(input logic [31:0] x);
    return (x == lat_x) ? lat_cfg : 0;
  endfunction

  logic [31:0] x_ld = '0;
  int          cnt  = 0;
  logic        fin  = 1'b0;

  // Stub: loads on tanh_reset, finishes lat_of(x) edges later; output corrupts if x moves
  always @(posedge clk) begin
    if (tanh_reset) begin
      x_ld <= tanh_x;
      cnt  <= 0;
      fin  <= !(hang_en && tanh_x == hang_x) && (lat_of(tanh_x) == 0);
    end else if (!fin && !(hang_en && x_ld == hang_x)) begin
      cnt <= cnt + 1;
      if (cnt + 1 >= lat_of(x_ld)) fin <= 1'b1;
    end
  end

  assign tanh_finished = fin;
  assign tanh_out      = (tanh_x == x_ld) ? f_tanh(x_ld) : 32'hDEADBEEF;

  // Monitors: load strobes while busy, and operand movement while the unit runs
  int rst_hi = 0;
  int hold_viol = 0;
  always @(negedge clk) begin
    if (busy && tanh_reset) rst_hi++;
    if (busy && !tanh_reset && tanh_x !== x_ld) hold_viol++;
  end

  task automatic pulse_start(input logic [DW*NE-1:0] v);
    @(negedge clk);
    data_in = v;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      cycles++;
      #1;
      if (done) return;
    end
    cycles = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    n_cmp++; if (tanh_x !== '0 || tanh_reset !== 1'b1) begin n_bad++; $display("FAIL reset_tanh: got x=%h r=%b want x=0 r=1", tanh_x, tanh_reset); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturating;
    int cyc; int r0;
    r0 = rst_hi;
    pulse_start({32'hC0000000, 32'h40000000, 32'hBF800000, 32'h3F800000});
    wait_done(cyc);
    n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL sat_latency: got %0d want 9", cyc); end
    n_cmp++; if (data_out !== {32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000}) begin
      n_bad++; $display("FAIL sat_data: got %h want bf8000003f800000bf8000003f800000", data_out); end
    n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL sat_flags: got err=%b busy=%b want 0 0", err, busy); end
    n_cmp++; if (rst_hi - r0 !== 4) begin n_bad++; $display("FAIL sat_loads: got %0d want 4", rst_hi - r0); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sat_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_general_latency;
    int cyc; int r0; int h0;
    lat_x = 32'h3F000000; lat_cfg = 3;
    r0 = rst_hi; h0 = hold_viol;
    pulse_start({32'h0, 32'h0, 32'h0, 32'h3F000000});
    wait_done(cyc);
    n_cmp++; if (cyc !== 12) begin n_bad++; $display("FAIL gen_latency: got %0d want 12", cyc); end
    n_cmp++; if (data_out !== {32'h0, 32'h0, 32'h0, 32'h3EEC9A9F}) begin
      n_bad++; $display("FAIL gen_data: got %h want 000000000000000000000000 3eec9a9f", data_out); end
    n_cmp++; if (rst_hi - r0 !== 4) begin n_bad++; $display("FAIL gen_loads: got %0d want 4", rst_hi - r0); end
    n_cmp++; if (hold_viol - h0 !== 0) begin n_bad++; $display("FAIL gen_x_hold: got %0d moves want 0", hold_viol - h0); end
    lat_x = 32'hFFFFFFFF; lat_cfg = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int cyc;
    hang_en = 1'b1; hang_x = 32'h12345678;
    pulse_start({32'h40000000, 32'h12345678, 32'hBF800000, 32'h3F800000});
    wait_done(cyc);
    n_cmp++; if (cyc !== 24) begin n_bad++; $display("FAIL to_latency: got %0d want 24", cyc); end
    n_cmp++; if (data_out !== {32'h3F800000, 32'h7FC00000, 32'hBF800000, 32'h3F800000}) begin
      n_bad++; $display("FAIL to_data: got %h want 3f8000007fc00000bf8000003f800000", data_out); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_set: got %b want 1", err); end
    hang_en = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err_sticky: got %b want 1", err); end
    pulse_start({32'h0, 32'h0, 32'h0, 32'h0});
    n_cmp++; if (err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_err_clear: got err=%b busy=%b want 0 1", err, busy); end
    wait_done(cyc);
    n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL to_rerun_latency: got %0d want 9", cyc); end
    @(negedge clk);
  endtask

  task automatic test_start_spam;
    int ndone;
    logic [DW*NE-1:0] va, vb;
    va = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    vb = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
    ndone = 0;
    @(negedge clk);
    data_in = va; start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
      if (ndone > 0) start = 1'b0;
      data_in = k[0] ? va : vb;
    end
    start = 1'b0;
    n_cmp++; if (ndone !== 1) begin n_bad++; $display("FAIL spam_done_count: got %0d want 1", ndone); end
    n_cmp++; if (data_out !== {32'h11111110, 32'h22222223, 32'h33333332, 32'h44444445}) begin
      n_bad++; $display("FAIL spam_data: got %h want 11111110222222233333333244444445", data_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL spam_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [DW*NE-1:0] v;
    v = {32'h66666666, 32'h55555555, 32'h44444444, 32'h33333333};
    lat_x = 32'h55555555; lat_cfg = 5;
    pulse_start(v);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_flags: got busy=%b done=%b want 0 0", busy, done); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL mid_reset_data: got %h want 0", data_out); end
    n_cmp++; if (tanh_reset !== 1'b1) begin n_bad++; $display("FAIL mid_reset_tanh_reset: got %b want 1", tanh_reset); end
    @(negedge clk);
    reset = 1'b0;
    pulse_start(v);
    wait_done(cyc);
    n_cmp++; if (cyc !== 14) begin n_bad++; $display("FAIL mid_rerun_latency: got %0d want 14", cyc); end
    n_cmp++; if (data_out !== {32'h66666667, 32'h55555554, 32'h44444445, 32'h33333332}) begin
      n_bad++; $display("FAIL mid_rerun_data: got %h want 66666667555555544444444533333332", data_out); end
    lat_x = 32'hFFFFFFFF; lat_cfg = 0;
    @(negedge clk);
  endtask

  task automatic test_stale_finished;
    int cyc;
    lat_x = 32'h3F000000; lat_cfg = 2;
    pulse_start({32'hC0000000, 32'h00000000, 32'h3F000000, 32'h3F800000});
    wait_done(cyc);
    n_cmp++; if (cyc !== 11) begin n_bad++; $display("FAIL stale_latency: got %0d want 11", cyc); end
    n_cmp++; if (data_out !== {32'hBF800000, 32'h00000000, 32'h3EEC9A9F, 32'h3F800000}) begin
      n_bad++; $display("FAIL stale_data: got %h want bf800000000000003eec9a9f3f800000", data_out); end
    lat_x = 32'hFFFFFFFF; lat_cfg = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_saturating();
    test_general_latency();
    test_timeout();
    test_start_spam();
    test_reset_mid();
    test_stale_finished();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
